// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register: owns the PC, keeps one request
// outstanding, drops responses made stale by a redirect and buffers one response under stall.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_req_ready_i,
    input  logic        inst_rvalid_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_inst_valid_o
);

    typedef enum logic [1:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_pc;
    logic [31:0] r_reqPc;
    logic        r_bufValid;
    logic [31:0] r_bufPc;
    logic [31:0] r_bufInst;
    logic [31:0] r_ifPc;
    logic [31:0] r_ifInst;
    logic        r_ifValid;

    logic        w_instReq;
    logic [31:0] w_instAddr;
    logic        w_accept;
    logic        w_deliver;

    assign w_accept  = w_instReq && inst_req_ready_i;
    // A response coinciding with a redirect belongs to the old path and is dropped.
    assign w_deliver = (r_state == S_WAIT) && inst_rvalid_i && !branch_flag_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_RESET: begin
                w_stateNext = S_REQ;
            end
            S_REQ: begin
                if (w_accept) begin
                    w_stateNext = branch_flag_i ? S_DISCARD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_rvalid_i) begin
                    w_stateNext = S_REQ;
                end else if (branch_flag_i) begin
                    w_stateNext = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (inst_rvalid_i) begin
                    w_stateNext = S_REQ;
                end
            end
            default: begin
                w_stateNext = S_RESET;
            end
        endcase
    end

    always_comb begin
        w_instReq  = 1'b0;
        w_instAddr = 32'h0;
        if (r_state == S_REQ) begin
            w_instReq  = !stall_i && !r_bufValid;
            w_instAddr = r_pc;
        end
    end

    assign inst_req_o  = w_instReq;
    assign inst_addr_o = w_instAddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_reqPc <= 32'h0;
        end else begin
            if (w_accept) begin
                r_reqPc <= r_pc;
            end
            if (branch_flag_i) begin
                r_pc <= branch_target_i;
            end else if (w_deliver) begin
                r_pc <= r_reqPc + PC_STEP;
            end
        end
    end

    // The buffer can only fill while stalled, and no request is issued while it is full.
    always_ff @(posedge clk) begin
        if (rst || branch_flag_i) begin
            r_bufValid <= 1'b0;
            r_bufPc    <= 32'h0;
            r_bufInst  <= 32'h0;
            r_ifValid  <= 1'b0;
            r_ifPc     <= 32'h0;
            r_ifInst   <= 32'h0;
        end else if (!stall_i) begin
            if (r_bufValid) begin
                r_ifValid  <= 1'b1;
                r_ifPc     <= r_bufPc;
                r_ifInst   <= r_bufInst;
                r_bufValid <= 1'b0;
            end else if (w_deliver) begin
                r_ifValid <= 1'b1;
                r_ifPc    <= r_reqPc;
                r_ifInst  <= inst_rdata_i;
            end else begin
                r_ifValid <= 1'b0;
            end
        end else if (w_deliver) begin
            r_bufValid <= 1'b1;
            r_bufPc    <= r_reqPc;
            r_bufInst  <= inst_rdata_i;
        end
    end

    assign if_pc_o         = r_ifPc;
    assign if_inst_o       = r_ifInst;
    assign if_inst_valid_o = r_ifValid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a cycle table for the redirect/stall/wrap/reset
// corners, then a randomised memory with a queue of expected deliveries.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h1c00_0000;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] Z   = 32'h0;

    logic        clk;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_req_ready_i;
    logic        inst_rvalid_i;
    logic [31:0] inst_rdata_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_inst_valid_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        eReq;
        logic        cAddr;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eInst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    logic        pending;
    int          countdown;
    logic [31:0] pendAddr;
    logic [31:0] expPc;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_req_ready_i(inst_req_ready_i),
        .inst_rvalid_i   (inst_rvalid_i),
        .inst_rdata_i    (inst_rdata_i),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o),
        .if_inst_valid_o (if_inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                                input logic s, input logic rd, input logic v,
                                input logic [31:0] d, input logic eq, input logic ca,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t x;
        x.rst = r; x.br = b; x.tgt = t; x.stall = s; x.rdy = rd; x.rv = v; x.rdata = d;
        x.eReq = eq; x.cAddr = ca; x.eAddr = ea; x.eValid = ev; x.ePc = ep; x.eInst = ei;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst              = v.rst;
        branch_flag_i    = v.br;
        branch_target_i  = v.tgt;
        stall_i          = v.stall;
        inst_req_ready_i = v.rdy;
        inst_rvalid_i    = v.rv;
        inst_rdata_i     = v.rdata;
    endtask

    // One cycle of the random memory: drives response/ready/stall, tracks acceptance and
    // scores every new presentation against the queue.
    task automatic streamCycle(input bit allowReq, input bit allowStall);
        logic wasStall;
        exp_t e;
        rst              = 1'b0;
        branch_flag_i    = 1'b0;
        branch_target_i  = $urandom;
        stall_i          = allowStall && ($urandom_range(0, 3) == 0);
        inst_req_ready_i = allowReq && ($urandom_range(0, 1) == 1);
        inst_rvalid_i    = 1'b0;
        inst_rdata_i     = $urandom;
        if (pending) begin
            if (countdown == 0) begin
                inst_rvalid_i = 1'b1;
                inst_rdata_i  = pendAddr ^ KEY;
                pending       = 1'b0;
            end else begin
                countdown--;
            end
        end
        #1;
        if (inst_req_o && inst_req_ready_i) begin
            checkOutput("stream_addr", inst_addr_o, expPc);
            e.pc   = expPc;
            e.inst = expPc ^ KEY;
            sb.push_back(e);
            pendAddr  = inst_addr_o;
            pending   = 1'b1;
            countdown = $urandom_range(0, 2);
            expPc     = expPc + 32'd4;
        end
        wasStall = stall_i;
        @(posedge clk);
        #1;
        if (!wasStall && if_inst_valid_o) begin
            if (sb.size() == 0) begin
                checkOutput("stream_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("stream_pc", if_pc_o, e.pc);
                checkOutput("stream_inst", if_inst_o, e.inst);
            end
        end
    endtask

    initial begin
        vec_t v;
        v = mk(1, 0, Z, 0, 0, 0, Z, 0, 0, Z, 0, Z, Z);
        applyStimulus(v);
        repeat (2) @(posedge clk);
        #1;

        // reset, then sequential fetches
        tbl.push_back(mk(1, 0, Z, 0, 0, 0, Z, 0, 1, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 0, Z, 0, 1, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, RPC, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'hb9a50000, 0, 0, Z, 1, RPC, 32'hb9a50000));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'h1c000004, 0, RPC, 32'hb9a50000));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'hb9a50004, 0, 0, Z, 1, 32'h1c000004, 32'hb9a50004));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'h1c000008, 0, 32'h1c000004, 32'hb9a50004));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'hb9a50008, 0, 0, Z, 1, 32'h1c000008, 32'hb9a50008));
        // branch in WAIT, stale response dropped
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'h1c00000c, 0, 32'h1c000008, 32'hb9a50008));
        tbl.push_back(mk(0, 1, 32'h1c000100, 0, 0, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'hdeadbeef, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 0, Z, 1, 0, 32'h1c000100, 0, Z, Z));
        // branch together with rvalid
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'h1c000100, 0, Z, Z));
        tbl.push_back(mk(0, 1, 32'h1c000200, 0, 0, 1, 32'h12345678, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 0, Z, 1, 0, 32'h1c000200, 0, Z, Z));
        // stall while the response is in flight
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'h1c000200, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 1, 0, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 1, 0, 1, 32'hb9a50200, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 1, 1, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 0, 0, Z, 1, 32'h1c000200, 32'hb9a50200));
        tbl.push_back(mk(0, 0, Z, 0, 0, 0, Z, 1, 0, 32'h1c000204, 0, 32'h1c000200, 32'hb9a50200));
        // branch on an accepted handshake, then wrap at the top of the address space
        tbl.push_back(mk(0, 1, 32'hfffffffc, 0, 1, 0, Z, 1, 0, 32'h1c000204, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'h0badf00d, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, 32'hfffffffc, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'h5a5afffc, 0, 0, Z, 1, 32'hfffffffc, 32'h5a5afffc));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, Z, 0, 32'hfffffffc, 32'h5a5afffc));
        // reset while discarding; rvalid in RESET and REQ is ignored
        tbl.push_back(mk(0, 1, 32'h1c000300, 0, 0, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(1, 0, Z, 0, 0, 0, Z, 0, 0, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'h11111111, 0, 1, Z, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'h22222222, 1, 0, RPC, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 1, 0, Z, 1, 0, RPC, 0, Z, Z));
        tbl.push_back(mk(0, 0, Z, 0, 0, 1, 32'hb9a50000, 0, 0, Z, 1, RPC, 32'hb9a50000));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            applyStimulus(v);
            #1;
            checkOutput($sformatf("row%0d_req", i), {31'h0, inst_req_o}, {31'h0, v.eReq});
            if (v.eReq || v.cAddr) begin
                checkOutput($sformatf("row%0d_addr", i), inst_addr_o, v.eAddr);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d_valid", i), {31'h0, if_inst_valid_o}, {31'h0, v.eValid});
            checkOutput($sformatf("row%0d_pc", i), if_pc_o, v.ePc);
            checkOutput($sformatf("row%0d_inst", i), if_inst_o, v.eInst);
        end

        v = mk(1, 0, Z, 0, 0, 0, Z, 0, 0, Z, 0, Z, Z);
        applyStimulus(v);
        repeat (2) @(posedge clk);
        #1;
        pending = 1'b0;
        countdown = 0;
        pendAddr = Z;
        expPc = RPC;
        for (int c = 0; c < 400; c++) begin
            streamCycle(1'b1, 1'b1);
        end
        for (int c = 0; c < 20; c++) begin
            if (!pending && sb.size() == 0) break;
            streamCycle(1'b0, 1'b0);
        end
        checkOutput("stream_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
